qpix_ctrl_core: RTL and testbench
=================================

// Module: qpix_ctrl_core
// PURPOSE
//  Register-driven controller for QPix ASIC test boards. Captures timestamped LVDS hit edges into an event FIFO.
//  Drives two 32-bit serial config interfaces with loadData one-shots, generates external reset pulses,
//  and produces gated replenishment clocks. Sits between the AXI register bank (flat reg_rw vector) and board I/O.
// PARAMETERS
//  FIFO_DEPTH    16     event FIFO entries (power of 2)
//  SCLK_DIV      4      serial clock half-period in clk cycles (SIM builds use a small value)
//  LOAD_CYCLES   5000   loadData one-shot width in clk cycles
//  RST_CYCLES    50     RST_EXT/RST_EXT2 pulse width in clk cycles
//  REPL_DIV      8      opad_CLK/opad2_CLK half-period in clk cycles
// PORTS
//  clk          in   1     sole clock; oLVDS pulses are >=1 clk wide
//  rst          in   1     async active-high reset; parent drives it from reg_rw[0]
//  oLVDS        in   16    hit lines from ASICs, rising edge = event
//  reg_rw       in   2048  64x32 RW regs, reg n = reg_rw[n*32+31:n*32]
//  fifo_dout    out  36    {chan[3:0], timestamp[31:0]} at FIFO head
//  fifo_empty   out  1     FIFO empty
//  fifo_full    out  1     FIFO full
//  fifo_count   out  5     occupancy
//  sclk         out  2     serial clocks (index 0 = if1, 1 = if2), gated
//  sdata        out  2     serial data, MSB first
//  sdone        out  2     shift complete
//  loadData     out  2     QPix loadData one-shots
//  selDefData   out  2     default-data select
//  RST_EXT      out  1     external reset 1
//  RST_EXT2     out  1     external reset 2
//  CAL          out  1     calibrate
//  opad_CLK     out  1     replenishment clock 1
//  opad2_CLK    out  1     replenishment clock 2
//  opad_startup out  1     beta-multiplier startup 1
//  opad_startup2 out 1     beta-multiplier startup 2
// BEHAVIOUR
//  - rst: every output, counter, shift register and FIFO pointer is cleared to 0; fifo_empty=1.
//  - All reg_rw bits are sampled in clk. "Rise" means the bit is 1 now and was 0 on the previous cycle.
//  - Timestamp is a 32-bit free-running counter that wraps.
//  - Events: reg5[0]=TRIGGER enables capture. Each oLVDS[i] rise with TRIGGER=1 writes {i, ts}.
//    Simultaneous rises are written lowest index first, one per cycle, from a 16-bit pending mask.
//    Write when full: entry dropped, no overwrite.
//  - Read: a rise of reg6[0] pops one entry; fifo_dout then shows the next entry 1 cycle later.
//    Pop when empty is ignored. Simultaneous push and pop keeps count unchanged.
//  - Serial if k (k=0 uses reg1 ctrl/reg2 data; k=1 uses reg3 ctrl/reg4 data):
//    - ctrl[1] rise loads the 32-bit data into the SR and clears sdone.
//    - ctrl[2]=1 and sdone=0 shift: sclk toggles every SCLK_DIV cycles; sdata changes on falling sclk,
//      MSB first. After 32 rising edges sclk is held 0 and sdone=1.
//    - ctrl[2]=0 mid-shift aborts: sclk=0, SR held.
//    - ctrl[8] rise starts a LOAD_CYCLES-wide loadData pulse. A rise during the pulse restarts the count.
//    - ctrl[9] drives selDefData, registered 1 cycle.
//  - reg0[2] rise gives an RST_CYCLES pulse on RST_EXT; reg0[3] does the same on RST_EXT2.
//    reg0[5] / reg0[6] are ORed in as level (manual) controls.
//  - CAL = reg0[4] registered.
//  - opad_CLK runs at clk/(2*REPL_DIV) while reg0[16]=1, else 0; opad2_CLK does the same from reg0[17].
//  - opad_startup = reg0[24], opad_startup2 = reg0[25], both registered.
// TESTING
//  - rst 500ns then release -> all outputs 0, fifo_empty=1, fifo_count=0.
//  - TRIGGER=1, two pulses on oLVDS[0] 500ns apart -> count=2, chan=0, second ts > first ts.
//    Two reg6[0] rises -> empty.
//  - TRIGGER=0, oLVDS[1] pulse -> count stays 0. Same rise on oLVDS[0] and [3] with TRIGGER=1 -> chan 0 then 3.
//  - reg2=0x12345678, reg1[1] rise, reg1[2]=1 -> sdata[0] bits 0,0,0,1,0,0,1,0... over 32 sclk; sdone[0]=1.
//    reg4=0xA0A0A0AF on if2 -> last bits 1,1,1,1.
//  - reg1[8] rise -> loadData[0] high exactly LOAD_CYCLES clks. reg0[2] rise -> RST_EXT high RST_CYCLES clks.
//  - Push FIFO_DEPTH+1 events -> fifo_full=1, count=16, extra entry dropped.
//    reg0[16]=1 -> opad_CLK period 2*REPL_DIV clks.

Source files
------------

// File: rtl/qpix_ctrl_core.sv
// qpix_ctrl_core: QPix test-board controller. Timestamps LVDS hit edges into
// an event FIFO, drives two serial config interfaces with loadData one-shots,
// and generates external reset pulses and gated replenishment clocks.

// One serial config channel: 32-bit MSB-first shifter plus loadData one-shot.
module qpix_ser_if #(
    parameter int SCLK_DIV    = 4,
    parameter int LOAD_CYCLES = 5000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] ctrl_i,
    input  logic [31:0] data_i,
    output logic        sclk_o,
    output logic        sdata_o,
    output logic        sdone_o,
    output logic        load_o,
    output logic        seldef_o
);
    localparam logic [15:0] DIV_LAST = 16'(SCLK_DIV - 1);
    localparam logic [31:0] LOAD_W   = 32'(LOAD_CYCLES);

    logic [31:0] sr_q, sr_d, lcnt_q, lcnt_d;
    logic [15:0] div_q, div_d;
    logic [5:0]  bits_q, bits_d;
    logic        sclk_q, sclk_d, done_q, done_d;
    logic        ld_prev_q, lp_prev_q, seldef_q;
    logic        ld_rise, lp_rise;
    logic        unused_ctrl;

    assign unused_ctrl = ^{ctrl_i[31:10], ctrl_i[7:3], ctrl_i[0]};
    assign ld_rise     = ctrl_i[1] & ~ld_prev_q;
    assign lp_rise     = ctrl_i[8] & ~lp_prev_q;

    // Shift sequencer: sclk toggles every SCLK_DIV cycles, data advances on falling sclk.
    always_comb begin
        sr_d   = sr_q;
        sclk_d = sclk_q;
        div_d  = div_q;
        bits_d = bits_q;
        done_d = done_q;
        if (ld_rise) begin
            sr_d   = data_i;
            sclk_d = 1'b0;
            div_d  = '0;
            bits_d = '0;
            done_d = 1'b0;
        end else if (ctrl_i[2] && !done_q) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                if (!sclk_q) begin
                    sclk_d = 1'b1;
                    bits_d = bits_q + 6'd1;
                end else begin
                    sclk_d = 1'b0;
                    if (bits_q == 6'd32) done_d = 1'b1;
                    else                 sr_d   = {sr_q[30:0], 1'b0};
                end
            end else begin
                div_d = div_q + 16'd1;
            end
        end else begin
            // idle, done or aborted: clock parked low, SR keeps its contents
            sclk_d = 1'b0;
            div_d  = '0;
        end
    end

    // loadData one-shot; a new rise reloads the full width.
    always_comb begin
        if (lp_rise)            lcnt_d = LOAD_W;
        else if (lcnt_q != '0)  lcnt_d = lcnt_q - 32'd1;
        else                    lcnt_d = '0;
    end

    // State registers for the channel.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sr_q      <= '0;
            div_q     <= '0;
            bits_q    <= '0;
            sclk_q    <= 1'b0;
            done_q    <= 1'b0;
            lcnt_q    <= '0;
            ld_prev_q <= 1'b0;
            lp_prev_q <= 1'b0;
            seldef_q  <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            div_q     <= div_d;
            bits_q    <= bits_d;
            sclk_q    <= sclk_d;
            done_q    <= done_d;
            lcnt_q    <= lcnt_d;
            ld_prev_q <= ctrl_i[1];
            lp_prev_q <= ctrl_i[8];
            seldef_q  <= ctrl_i[9];
        end
    end

    assign sclk_o   = sclk_q;
    assign sdata_o  = sr_q[31];
    assign sdone_o  = done_q;
    assign load_o   = (lcnt_q != '0);
    assign seldef_o = seldef_q;
endmodule

module qpix_ctrl_core #(
    parameter int FIFO_DEPTH  = 16,
    parameter int SCLK_DIV    = 4,
    parameter int LOAD_CYCLES = 5000,
    parameter int RST_CYCLES  = 50,
    parameter int REPL_DIV    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [15:0]                   oLVDS,
    input  logic [2047:0]                 reg_rw,
    output logic [35:0]                   fifo_dout,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [1:0]                    sclk,
    output logic [1:0]                    sdata,
    output logic [1:0]                    sdone,
    output logic [1:0]                    loadData,
    output logic [1:0]                    selDefData,
    output logic                          RST_EXT,
    output logic                          RST_EXT2,
    output logic                          CAL,
    output logic                          opad_CLK,
    output logic                          opad2_CLK,
    output logic                          opad_startup,
    output logic                          opad_startup2
);
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [15:0] RST_W    = 16'(RST_CYCLES);
    localparam logic [15:0] REPL_LST = 16'(REPL_DIV - 1);

    logic [31:0] reg0;
    logic        trigger, pop_req;
    logic        unused_regs;

    assign reg0        = reg_rw[31:0];
    assign trigger     = reg_rw[5*32];
    assign unused_regs = ^reg_rw;

    // ---------------- event capture ----------------
    logic [31:0] ts_q;
    logic [15:0] lvds_q, pend_q, pend_d, pend_all, sel_oh;
    logic [3:0]  sel_idx;
    logic        found, push_ok, pop_ok, rd_prev_q;
    logic [AW:0] wr_q, rd_q;
    logic [35:0] mem_q [FIFO_DEPTH];

    // Pick the lowest pending channel each cycle; it leaves the mask even if dropped.
    always_comb begin
        pend_all = pend_q | (oLVDS & ~lvds_q & {16{trigger}});
        sel_oh   = '0;
        sel_idx  = '0;
        found    = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (pend_all[i] && !found) begin
                found     = 1'b1;
                sel_idx   = 4'(i);
                sel_oh[i] = 1'b1;
            end
        end
        pend_d = pend_all & ~sel_oh;
    end

    assign fifo_count = wr_q - rd_q;
    assign fifo_empty = (wr_q == rd_q);
    assign fifo_full  = fifo_count[AW];
    assign push_ok    = found & ~fifo_full;
    assign pop_req    = reg_rw[6*32] & ~rd_prev_q;
    assign pop_ok     = pop_req & ~fifo_empty;
    assign fifo_dout  = fifo_empty ? 36'd0 : mem_q[rd_q[AW-1:0]];

    // Timestamp, edge detect, pending mask and FIFO pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q      <= '0;
            lvds_q    <= '0;
            pend_q    <= '0;
            rd_prev_q <= 1'b0;
            wr_q      <= '0;
            rd_q      <= '0;
        end else begin
            ts_q      <= ts_q + 32'd1;
            lvds_q    <= oLVDS;
            pend_q    <= pend_d;
            rd_prev_q <= reg_rw[6*32];
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop_ok)  rd_q <= rd_q + 1'b1;
        end
    end

    // FIFO storage; contents are masked at the output while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= {sel_idx, ts_q};
    end

    // ---------------- serial config interfaces ----------------
    for (genvar k = 0; k < 2; k++) begin : g_ser
        qpix_ser_if #(.SCLK_DIV(SCLK_DIV), .LOAD_CYCLES(LOAD_CYCLES)) u_ser (
            .clk_i    (clk),
            .rst_i    (rst),
            .ctrl_i   (reg_rw[(2*k+1)*32 +: 32]),
            .data_i   (reg_rw[(2*k+2)*32 +: 32]),
            .sclk_o   (sclk[k]),
            .sdata_o  (sdata[k]),
            .sdone_o  (sdone[k]),
            .load_o   (loadData[k]),
            .seldef_o (selDefData[k])
        );
    end

    // ---------------- resets, levels, replenishment clocks ----------------
    logic [15:0] rcnt_q [2];
    logic [15:0] pcnt_q [2];
    logic [1:0]  rprev_q, man_q, start_q, repl_q;
    logic        cal_q;

    // Reset one-shots, registered level controls and gated divided clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt_q  <= '{default: '0};
            pcnt_q  <= '{default: '0};
            rprev_q <= '0;
            man_q   <= '0;
            start_q <= '0;
            repl_q  <= '0;
            cal_q   <= 1'b0;
        end else begin
            rprev_q <= reg0[3:2];
            man_q   <= reg0[6:5];
            start_q <= reg0[25:24];
            cal_q   <= reg0[4];
            for (int j = 0; j < 2; j++) begin
                if (reg0[2+j] && !rprev_q[j]) rcnt_q[j] <= RST_W;
                else if (rcnt_q[j] != '0)     rcnt_q[j] <= rcnt_q[j] - 16'd1;
                if (!reg0[16+j]) begin
                    repl_q[j] <= 1'b0;
                    pcnt_q[j] <= '0;
                end else if (pcnt_q[j] == REPL_LST) begin
                    repl_q[j] <= ~repl_q[j];
                    pcnt_q[j] <= '0;
                end else begin
                    pcnt_q[j] <= pcnt_q[j] + 16'd1;
                end
            end
        end
    end

    assign RST_EXT       = (rcnt_q[0] != '0) | man_q[0];
    assign RST_EXT2      = (rcnt_q[1] != '0) | man_q[1];
    assign CAL           = cal_q;
    assign opad_CLK      = repl_q[0];
    assign opad2_CLK     = repl_q[1];
    assign opad_startup  = start_q[0];
    assign opad_startup2 = start_q[1];
endmodule

// File: tb/tb_qpix_ctrl_core.sv
// Bench for qpix_ctrl_core: event capture/FIFO, serial shifting, one-shots,
// level controls and replenishment clocks against a queue-based model.
module tb_qpix_ctrl_core;
    localparam int FD = 16, SD = 2, LC = 200, RC = 50, RD = 8;

    logic          clk = 1'b0, rst = 1'b1;
    logic [15:0]   oLVDS = '0;
    logic [2047:0] reg_rw = '0;
    logic [35:0]   fifo_dout;
    logic          fifo_empty, fifo_full;
    logic [4:0]    fifo_count;
    logic [1:0]    sclk, sdata, sdone, loadData, selDefData;
    logic          RST_EXT, RST_EXT2, CAL, opad_CLK, opad2_CLK, opad_startup, opad_startup2;

    qpix_ctrl_core #(.FIFO_DEPTH(FD), .SCLK_DIV(SD), .LOAD_CYCLES(LC),
                     .RST_CYCLES(RC), .REPL_DIV(RD)) dut (
        .clk(clk), .rst(rst), .oLVDS(oLVDS), .reg_rw(reg_rw),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .fifo_count(fifo_count), .sclk(sclk), .sdata(sdata), .sdone(sdone),
        .loadData(loadData), .selDefData(selDefData), .RST_EXT(RST_EXT),
        .RST_EXT2(RST_EXT2), .CAL(CAL), .opad_CLK(opad_CLK), .opad2_CLK(opad2_CLK),
        .opad_startup(opad_startup), .opad_startup2(opad_startup2));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, failures = 0;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic setbit(input int r, input int b, input logic v);
        reg_rw[r*32+b] = v;
    endtask

    task automatic setreg(input int r, input logic [31:0] v);
        reg_rw[r*32 +: 32] = v;
    endtask

    task automatic pulse(input logic [15:0] m);
        oLVDS = m;
        tick(2);
        oLVDS = '0;
    endtask

    task automatic pop();
        setbit(6, 0, 1'b1);
        tick(1);
        setbit(6, 0, 1'b0);
        tick(1);
    endtask

    function automatic logic sigval(input int w);
        case (w)
            0:       return loadData[0];
            1:       return loadData[1];
            2:       return RST_EXT;
            3:       return RST_EXT2;
            4:       return opad_CLK;
            default: return opad2_CLK;
        endcase
    endfunction

    task automatic pulse_width(input int w, output int n);
        n = 0;
        tick(1);
        while (sigval(w) && n < 5000) begin
            n++;
            tick(1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #500;
        @(negedge clk);
        rst = 1'b0;
        tick(1);
        checks++;
        if (fifo_empty !== 1'b1 || fifo_count !== 5'd0 || fifo_full !== 1'b0) begin
            failures++;
            $display("FAIL reset_fifo: empty=%b count=%0d full=%b, want 1/0/0", fifo_empty, fifo_count, fifo_full);
        end
        checks++;
        if (fifo_dout !== 36'd0) begin
            failures++;
            $display("FAIL reset_dout: got %h want 0", fifo_dout);
        end
        checks++;
        if ({sclk, sdata, sdone, loadData, selDefData} !== 10'd0) begin
            failures++;
            $display("FAIL reset_serial: got %b want 0", {sclk, sdata, sdone, loadData, selDefData});
        end
        checks++;
        if ({RST_EXT, RST_EXT2, CAL, opad_CLK, opad2_CLK, opad_startup, opad_startup2} !== 7'd0) begin
            failures++;
            $display("FAIL reset_misc: got %b want 0",
                     {RST_EXT, RST_EXT2, CAL, opad_CLK, opad2_CLK, opad_startup, opad_startup2});
        end
    endtask

    task automatic test_events();
        logic [35:0] h1, h2;
        setbit(5, 0, 1'b1);
        tick(1);
        pulse(16'h0001);
        tick(48);
        pulse(16'h0001);
        tick(20);
        checks++;
        if (fifo_count !== 5'd2) begin
            failures++;
            $display("FAIL ev_count: got %0d want 2", fifo_count);
        end
        h1 = fifo_dout;
        pop();
        h2 = fifo_dout;
        checks++;
        if (h1[35:32] !== 4'd0 || h2[35:32] !== 4'd0) begin
            failures++;
            $display("FAIL ev_chan: got %0d,%0d want 0,0", h1[35:32], h2[35:32]);
        end
        checks++;
        if (h2[31:0] <= h1[31:0] || h2[31:0] - h1[31:0] !== 32'd50) begin
            failures++;
            $display("FAIL ev_ts: ts1=%0d ts2=%0d want ts2-ts1=50", h1[31:0], h2[31:0]);
        end
        pop();
        checks++;
        if (fifo_empty !== 1'b1 || fifo_count !== 5'd0) begin
            failures++;
            $display("FAIL ev_drain: empty=%b count=%0d want 1/0", fifo_empty, fifo_count);
        end
        pop();
        checks++;
        if (fifo_empty !== 1'b1 || fifo_count !== 5'd0) begin
            failures++;
            $display("FAIL ev_pop_empty: empty=%b count=%0d want 1/0", fifo_empty, fifo_count);
        end
    endtask

    task automatic test_trigger();
        logic [35:0] h1, h2;
        setbit(5, 0, 1'b0);
        pulse(16'h0002);
        tick(20);
        checks++;
        if (fifo_count !== 5'd0) begin
            failures++;
            $display("FAIL trig_off: count=%0d want 0", fifo_count);
        end
        setbit(5, 0, 1'b1);
        pulse(16'h0009);
        tick(20);
        checks++;
        if (fifo_count !== 5'd2) begin
            failures++;
            $display("FAIL simul_count: got %0d want 2", fifo_count);
        end
        h1 = fifo_dout;
        pop();
        h2 = fifo_dout;
        pop();
        checks++;
        if (h1[35:32] !== 4'd0 || h2[35:32] !== 4'd3 || h2[31:0] - h1[31:0] !== 32'd1) begin
            failures++;
            $display("FAIL simul_order: chans %0d,%0d dts=%0d want 0,3 dts=1",
                     h1[35:32], h2[35:32], h2[31:0] - h1[31:0]);
        end
    endtask

    task automatic test_random_events();
        int exp_q[$];
        logic [15:0] m;
        logic [31:0] t0;
        for (int it = 0; it < 6; it++) begin
            m = 16'($urandom_range(1, 65535));
            exp_q.delete();
            for (int c = 0; c < 16; c++) if (m[c]) exp_q.push_back(c);
            pulse(m);
            tick(20);
            checks++;
            if (fifo_count !== 5'(exp_q.size())) begin
                failures++;
                $display("FAIL rnd_count: mask=%h got %0d want %0d", m, fifo_count, exp_q.size());
            end
            t0 = fifo_dout[31:0];
            for (int j = 0; j < exp_q.size(); j++) begin
                checks++;
                if (fifo_dout[35:32] !== 4'(exp_q[j]) || fifo_dout[31:0] !== t0 + 32'(j)) begin
                    failures++;
                    $display("FAIL rnd_entry: mask=%h idx=%0d got chan %0d ts %0d want chan %0d ts %0d",
                             m, j, fifo_dout[35:32], fifo_dout[31:0], exp_q[j], t0 + 32'(j));
                end
                pop();
            end
            checks++;
            if (fifo_empty !== 1'b1) begin
                failures++;
                $display("FAIL rnd_empty: empty=%b want 1", fifo_empty);
            end
        end
    endtask

    task automatic test_full();
        pulse(16'hFFFF);
        tick(20);
        pulse(16'h0020);
        tick(5);
        checks++;
        if (fifo_full !== 1'b1 || fifo_count !== 5'd16) begin
            failures++;
            $display("FAIL full: full=%b count=%0d want 1/16", fifo_full, fifo_count);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (fifo_dout[35:32] !== 4'(i) || fifo_empty !== 1'b0) begin
                failures++;
                $display("FAIL full_drain: idx=%0d got chan %0d empty %b want chan %0d", i,
                         fifo_dout[35:32], fifo_empty, i);
            end
            pop();
        end
        checks++;
        if (fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin
            failures++;
            $display("FAIL full_dropped: empty=%b full=%b want 1/0", fifo_empty, fifo_full);
        end
    endtask

    task automatic test_serial(input int k, input logic [31:0] data);
        int rc, rdt, n, c;
        logic [31:0] got;
        logic prev;
        rc  = k ? 3 : 1;
        rdt = k ? 4 : 2;
        got = '0;
        setreg(rdt, data);
        setreg(rc, 32'h2);
        tick(1);
        checks++;
        if (sdone[k] !== 1'b0) begin
            failures++;
            $display("FAIL ser_load%0d: sdone=%b want 0", k, sdone[k]);
        end
        setreg(rc, 32'h6);
        n = 0;
        c = 0;
        prev = sclk[k];
        while (!sdone[k] && c < 2000) begin
            tick(1);
            c++;
            if (sclk[k] && !prev) begin
                if (n < 32) got[31-n] = sdata[k];
                n++;
            end
            prev = sclk[k];
        end
        checks++;
        if (n !== 32 || got !== data) begin
            failures++;
            $display("FAIL ser_bits%0d: edges=%0d bits=%h want 32 edges bits=%h", k, n, got, data);
        end
        tick(3);
        checks++;
        if (sdone[k] !== 1'b1 || sclk[k] !== 1'b0) begin
            failures++;
            $display("FAIL ser_done%0d: sdone=%b sclk=%b want 1/0", k, sdone[k], sclk[k]);
        end
        setreg(rc, 32'h0);
        tick(1);
    endtask

    task automatic test_pulses();
        int n;
        setbit(1, 8, 1'b1);
        pulse_width(0, n);
        checks++;
        if (n !== LC) begin
            failures++;
            $display("FAIL load0_width: got %0d want %0d", n, LC);
        end
        setbit(1, 8, 1'b0);
        setbit(3, 8, 1'b1);
        setbit(0, 3, 1'b1);
        pulse_width(1, n);
        checks++;
        if (n !== LC) begin
            failures++;
            $display("FAIL load1_width: got %0d want %0d", n, LC);
        end
        setbit(3, 8, 1'b0);
        setbit(0, 3, 1'b0);
        tick(2);
        // restart: second rise 51 cycles into the pulse re-arms the full width
        setbit(1, 8, 1'b1);
        tick(50);
        setbit(1, 8, 1'b0);
        tick(1);
        setbit(1, 8, 1'b1);
        pulse_width(0, n);
        checks++;
        if (n !== LC) begin
            failures++;
            $display("FAIL load_restart: got %0d want %0d", n, LC);
        end
        setbit(1, 8, 1'b0);
        setbit(0, 2, 1'b1);
        pulse_width(2, n);
        checks++;
        if (n !== RC) begin
            failures++;
            $display("FAIL rst_ext_width: got %0d want %0d", n, RC);
        end
        setbit(0, 2, 1'b0);
        tick(1);
        setbit(0, 3, 1'b1);
        pulse_width(3, n);
        checks++;
        if (n !== RC) begin
            failures++;
            $display("FAIL rst_ext2_width: got %0d want %0d", n, RC);
        end
        setbit(0, 3, 1'b0);
        setbit(0, 5, 1'b1);
        setbit(0, 6, 1'b1);
        tick(2);
        checks++;
        if (RST_EXT !== 1'b1 || RST_EXT2 !== 1'b1) begin
            failures++;
            $display("FAIL rst_manual_on: got %b%b want 11", RST_EXT, RST_EXT2);
        end
        setbit(0, 5, 1'b0);
        setbit(0, 6, 1'b0);
        tick(2);
        checks++;
        if (RST_EXT !== 1'b0 || RST_EXT2 !== 1'b0) begin
            failures++;
            $display("FAIL rst_manual_off: got %b%b want 00", RST_EXT, RST_EXT2);
        end
    endtask

    task automatic test_levels();
        logic [4:0] v;
        for (int it = 0; it < 6; it++) begin
            v = 5'($urandom);
            setbit(0, 4, v[0]);
            setbit(0, 24, v[1]);
            setbit(0, 25, v[2]);
            setbit(1, 9, v[3]);
            setbit(3, 9, v[4]);
            tick(2);
            checks++;
            if ({selDefData[1], selDefData[0], opad_startup2, opad_startup, CAL} !== v) begin
                failures++;
                $display("FAIL levels: got %b want %b",
                         {selDefData[1], selDefData[0], opad_startup2, opad_startup, CAL}, v);
            end
        end
        setreg(0, 32'h0);
        setbit(1, 9, 1'b0);
        setbit(3, 9, 1'b0);
        tick(2);
    endtask

    task automatic test_opad();
        int t[3];
        int n, c;
        logic prev;
        for (int w = 0; w < 2; w++) begin
            setbit(0, 16 + w, 1'b1);
            n = 0;
            c = 0;
            prev = sigval(4 + w);
            while (n < 3 && c < 300) begin
                tick(1);
                c++;
                if (sigval(4 + w) && !prev) begin
                    t[n] = cyc;
                    n++;
                end
                prev = sigval(4 + w);
            end
            checks++;
            if (n !== 3 || t[1] - t[0] !== 2*RD || t[2] - t[1] !== 2*RD) begin
                failures++;
                $display("FAIL opad%0d_period: edges=%0d periods %0d,%0d want %0d", w, n,
                         t[1] - t[0], t[2] - t[1], 2*RD);
            end
            setbit(0, 16 + w, 1'b0);
            tick(2);
            checks++;
            if (opad_CLK !== 1'b0 || opad2_CLK !== 1'b0) begin
                failures++;
                $display("FAIL opad%0d_off: got %b%b want 00", w, opad_CLK, opad2_CLK);
            end
        end
    endtask

    initial begin
        test_reset();
        test_events();
        test_trigger();
        test_random_events();
        test_full();
        test_serial(0, 32'h12345678);
        test_serial(1, 32'hA0A0A0AF);
        test_serial(0, $urandom);
        test_pulses();
        test_levels();
        test_opad();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
